// File: rtl/blk_ae99ea_if.sv
// Report handshake bundle of the deadlock report controller.
// The controller drives the report fields; the consumer drives rpt_ready.
interface blk_ae99ea_if #(
  parameter int PROC_NUM = 4,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 16
);
  logic                rpt_valid;
  logic                rpt_ready;
  logic [IDX_W-1:0]    rpt_origin;
  logic [PROC_NUM-1:0] rpt_members;
  logic [CNT_W-1:0]    rpt_cycle;

  modport master (
    output rpt_valid,
    output rpt_origin,
    output rpt_members,
    output rpt_cycle,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_origin,
    input  rpt_members,
    input  rpt_cycle,
    output rpt_ready
  );
endinterface

// File: rtl/blk_ae99ea.sv
// Deadlock report sequencer: confirm a persistent dl_detect, inject and
// trace the token around the cycle, then hold one report until cleared.
module blk_ae99ea #(
  parameter int PROC_NUM       = 4,
  parameter int CONFIRM_CYCLES = 16,
  parameter int TRACE_TIMEOUT  = 64,
  parameter int CNT_W          = 16,
  parameter int IDX_W          = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                deadlock,
  input  logic                clear,
  blk_ae99ea_if.master        rpt
);
  localparam int CF_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int TR_W = $clog2(TRACE_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, CONFIRM, ORIGIN, TRACE, REPORT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]    stamp_q, stamp_d;
  logic [IDX_W-1:0]    cand_q, cand_d;
  logic [CF_W-1:0]     conf_q, conf_d;
  logic [TR_W-1:0]     trace_q, trace_d;
  logic [PROC_NUM-1:0] members_q, members_d;
  logic [PROC_NUM-1:0] origin_q, origin_d;
  logic                tclr_q, tclr_d;
  logic                dead_q, dead_d;
  logic                valid_q, valid_d;

  logic [IDX_W-1:0]    low_idx;
  logic                tok_ret;
  logic                tmo;

  always_comb begin
    low_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_detect_vec[i]) low_idx = IDX_W'(i);
    end
  end

  // first trace cycle ignored: units may still hold dl_detect from confirm
  assign tok_ret = dl_detect_vec[cand_q] && (trace_q != '0);
  assign tmo     = (trace_q == TR_W'(TRACE_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cyc_d     = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
    stamp_d   = stamp_q;
    cand_d    = cand_q;
    conf_d    = conf_q;
    trace_d   = trace_q;
    members_d = members_q;
    origin_d  = '0;
    tclr_d    = 1'b0;
    dead_d    = dead_q;
    valid_d   = valid_q;
    if (clear && state_q != IDLE) begin
      state_d   = IDLE;
      dead_d    = 1'b0;
      valid_d   = 1'b0;
      members_d = '0;
      conf_d    = '0;
      trace_d   = '0;
      tclr_d    = (state_q == ORIGIN) || (state_q == TRACE);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|dl_detect_vec) begin
            cand_d = low_idx;
            conf_d = CF_W'(1);
            if (CONFIRM_CYCLES == 1) begin
              state_d  = ORIGIN;
              origin_d = PROC_NUM'(1) << low_idx;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (dl_detect_vec[cand_q]) begin
            conf_d = conf_q + 1'b1;
            if (conf_q + 1'b1 == CF_W'(CONFIRM_CYCLES)) begin
              state_d  = ORIGIN;
              origin_d = PROC_NUM'(1) << cand_q;
            end
          end else begin
            state_d = IDLE;
            conf_d  = '0;
          end
        end
        ORIGIN: begin
          members_d = PROC_NUM'(1) << cand_q;
          stamp_d   = cyc_q;
          trace_d   = '0;
          conf_d    = '0;
          state_d   = TRACE;
        end
        TRACE: begin
          members_d = members_q | dl_detect_vec;
          trace_d   = trace_q + 1'b1;
          if (tok_ret) begin
            state_d = REPORT;
            tclr_d  = 1'b1;
            dead_d  = 1'b1;
            valid_d = 1'b1;
          end else if (tmo) begin
            state_d = IDLE;
            tclr_d  = 1'b1;
            trace_d = '0;
          end
        end
        REPORT: begin
          if (rpt.rpt_ready) begin
            state_d = DONE;
            valid_d = 1'b0;
          end
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      stamp_q   <= '0;
      cand_q    <= '0;
      conf_q    <= '0;
      trace_q   <= '0;
      members_q <= '0;
      origin_q  <= '0;
      tclr_q    <= 1'b0;
      dead_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stamp_q   <= stamp_d;
      cand_q    <= cand_d;
      conf_q    <= conf_d;
      trace_q   <= trace_d;
      members_q <= members_d;
      origin_q  <= origin_d;
      tclr_q    <= tclr_d;
      dead_q    <= dead_d;
      valid_q   <= valid_d;
    end
  end

  assign origin_vec      = origin_q;
  assign token_clear     = tclr_q;
  assign deadlock        = dead_q;
  assign rpt.rpt_valid   = valid_q;
  assign rpt.rpt_origin  = cand_q;
  assign rpt.rpt_members = members_q;
  assign rpt.rpt_cycle   = stamp_q;
endmodule

// File: tb/tb_blk_ae99ea.sv
// Directed bench for blk_ae99ea with an expected-report scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_blk_ae99ea;
  logic       clock;
  logic       reset;
  logic [3:0] dl;
  logic [3:0] origin_vec;
  logic       token_clear;
  logic       deadlock;
  logic       clear;

  blk_ae99ea_if #(.PROC_NUM(4), .IDX_W(2), .CNT_W(16)) rif ();

  blk_ae99ea #(
    .PROC_NUM(4), .CONFIRM_CYCLES(16), .TRACE_TIMEOUT(64),
    .CNT_W(16), .IDX_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dl_detect_vec(dl),
    .origin_vec(origin_vec),
    .token_clear(token_clear),
    .deadlock(deadlock),
    .clear(clear),
    .rpt(rif.master)
  );

  typedef struct {
    logic [1:0]  org;
    logic [3:0]  mem;
    logic [15:0] cyc;
  } rpt_t;

  rpt_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] n;
  logic [15:0] n0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference cycle count: reset to 0, +1 per edge, saturating
  always @(posedge clock or posedge reset) begin
    if (reset) n <= '0;
    else if (n != 16'hFFFF) n <= n + 16'd1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rpt(input string tag);
    rpt_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb[0];
      check({tag, "_valid"}, 32'(rif.rpt_valid), 32'd1);
      check({tag, "_origin"}, 32'(rif.rpt_origin), 32'(e.org));
      check({tag, "_members"}, 32'(rif.rpt_members), 32'(e.mem));
      check({tag, "_cycle"}, 32'(rif.rpt_cycle), 32'(e.cyc));
    end
  endtask

  initial begin : seq
    int tc_cnt;
    int tc_at;
    int vseen;
    int oseen;
    reset = 1'b1;
    dl = '0;
    clear = 1'b0;
    rif.rpt_ready = 1'b0;
    #12;
    check("rst_origin", 32'(origin_vec), 32'd0);
    check("rst_tclr", 32'(token_clear), 32'd0);
    check("rst_valid", 32'(rif.rpt_valid), 32'd0);
    check("rst_dead", 32'(deadlock), 32'd0);
    check("rst_members", 32'(rif.rpt_members), 32'd0);
    check("rst_cycle", 32'(rif.rpt_cycle), 32'd0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // single candidate, token returns on trace cycle 3
    n0 = n;
    sb.push_back('{2'd2, 4'b0110, n0 + 16'd16});
    dl = 4'b0100;
    repeat (16) step();
    check("s1_origin", 32'(origin_vec), 32'b0100);
    dl = 4'b0000;
    step();
    check("s1_origin_off", 32'(origin_vec), 32'd0);
    step();
    dl = 4'b0010;
    step();
    dl = 4'b0000;
    step();
    dl = 4'b0100;
    step();
    dl = 4'b0000;
    check("s1_tclr", 32'(token_clear), 32'd1);
    check("s1_dead", 32'(deadlock), 32'd1);
    check_rpt("s1");
    rif.rpt_ready = 1'b1;
    step();
    rif.rpt_ready = 1'b0;
    void'(sb.pop_front());
    check("s1_tclr_off", 32'(token_clear), 32'd0);
    check("s1_valid_off", 32'(rif.rpt_valid), 32'd0);
    check("s1_dead_hold", 32'(deadlock), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("s1_clr_dead", 32'(deadlock), 32'd0);
    step();

    // candidate drops after 10 cycles: no origin, no report
    dl = 4'b0010;
    repeat (10) step();
    dl = 4'b0000;
    oseen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (origin_vec != 4'b0000) oseen++;
    end
    check("s2_no_origin", 32'(oseen), 32'd0);
    check("s2_dead", 32'(deadlock), 32'd0);

    // two bits set: lowest index wins; consumer stalls 5 cycles
    n0 = n;
    sb.push_back('{2'd1, 4'b1010, n0 + 16'd16});
    dl = 4'b1010;
    repeat (16) step();
    check("s3_origin", 32'(origin_vec), 32'b0010);
    repeat (3) step();
    check("s3_tclr", 32'(token_clear), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_rpt("s5_stall");
      step();
    end
    rif.rpt_ready = 1'b1;
    step();
    rif.rpt_ready = 1'b0;
    void'(sb.pop_front());
    check("s5_valid_off", 32'(rif.rpt_valid), 32'd0);
    check("s5_dead", 32'(deadlock), 32'd1);
    oseen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (origin_vec != 4'b0000 || rif.rpt_valid) oseen++;
    end
    check("s5_done_idle", 32'(oseen), 32'd0);
    check("s5_done_origin", 32'(rif.rpt_origin), 32'd1);
    dl = 4'b0000;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("s5_clr_dead", 32'(deadlock), 32'd0);
    check("s5_clr_valid", 32'(rif.rpt_valid), 32'd0);
    step();

    // no token return: timeout after 64 trace cycles
    dl = 4'b0001;
    repeat (16) step();
    dl = 4'b0000;
    tc_cnt = 0;
    tc_at = 0;
    vseen = 0;
    for (int k = 16; k <= 90; k++) begin
      if (token_clear) begin
        tc_cnt++;
        tc_at = k;
      end
      if (rif.rpt_valid) vseen++;
      step();
    end
    check("s4_tclr_cnt", 32'(tc_cnt), 32'd1);
    check("s4_tclr_at", 32'(tc_at), 32'd81);
    check("s4_no_valid", 32'(vseen), 32'd0);
    check("s4_dead", 32'(deadlock), 32'd0);

    // clear beats accept in the same REPORT cycle
    n0 = n;
    sb.push_back('{2'd3, 4'b1000, n0 + 16'd16});
    dl = 4'b1000;
    repeat (19) step();
    check_rpt("s6");
    void'(sb.pop_front());
    dl = 4'b0000;
    rif.rpt_ready = 1'b1;
    clear = 1'b1;
    step();
    rif.rpt_ready = 1'b0;
    clear = 1'b0;
    check("s6_valid", 32'(rif.rpt_valid), 32'd0);
    check("s6_dead", 32'(deadlock), 32'd0);
    check("s6_members", 32'(rif.rpt_members), 32'd0);
    check("s6_tclr", 32'(token_clear), 32'd0);
    step();

    // asynchronous reset in the middle of TRACE
    dl = 4'b0100;
    repeat (16) step();
    dl = 4'b0000;
    repeat (2) step();
    reset = 1'b1;
    #1;
    check("s7_origin", 32'(origin_vec), 32'd0);
    check("s7_tclr", 32'(token_clear), 32'd0);
    check("s7_members", 32'(rif.rpt_members), 32'd0);
    check("s7_cycle", 32'(rif.rpt_cycle), 32'd0);
    step();
    reset = 1'b0;
    n0 = n;
    sb.push_back('{2'd1, 4'b0010, n0 + 16'd16});
    dl = 4'b0010;
    repeat (16) step();
    check("s7_origin_new", 32'(origin_vec), 32'b0010);
    repeat (3) step();
    check_rpt("s7");
    void'(sb.pop_front());
    dl = 4'b0000;
    rif.rpt_ready = 1'b1;
    step();
    rif.rpt_ready = 1'b0;
    check("s7_valid_off", 32'(rif.rpt_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
